dispatch_unit: RTL and testbench

- Producer side of the 7-entry compacting issue queue. Buffers up to two fetched instructions per cycle in an in-order FIFO.
- Drives inst0/inst1/wen into the issue queue, at most two per cycle, oldest first.
- Tracks free issue-queue slots with a credit counter: released slots are counted from out_en, consumed slots from wen. It never writes more instructions than there are free slots.
- Sits between fetch/decode and the issue queue.

---
 rtl/dispatch_unit.sv | 125 ++++++++++++
 tb/tb_dispatch_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_unit.sv
// Dispatch unit: in-order FIFO between fetch/decode and the 7-entry compacting
// issue queue. Up to two instructions per cycle are accepted, and up to two
// per cycle are written to the issue queue, oldest first. A credit counter
// tracks free issue-queue slots so the queue is never overrun.
module dispatch_unit #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int IQ_DEPTH   = 7
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          flush,
  input  logic [1:0]                    fetch_valid,
  input  logic [DATA_W-1:0]             fetch_inst0,
  input  logic [DATA_W-1:0]             fetch_inst1,
  output logic                          fetch_ready,
  output logic [DATA_W-1:0]             iq_inst0,
  output logic [DATA_W-1:0]             iq_inst1,
  output logic [1:0]                    iq_wen,
  input  logic [7:0]                    iq_out_en,
  output logic [3:0]                    iq_free,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [3:0]       IQ_MAX  = 4'(IQ_DEPTH);

  logic [DATA_W-1:0] mem_p0 [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_p0;
  logic [PTR_W-1:0]  wr_ptr_p0;
  logic [CNT_W-1:0]  count_p0;
  logic [3:0]        free_p0;

  logic [1:0]        push_n;
  logic [1:0]        pop_n;
  logic [3:0]        ret_n;
  logic [4:0]        credit_sum;
  logic [CNT_W-1:0]  space;
  logic              unused_out_en7;

  // Clamp the credit count to the issue-queue capacity.
  function automatic logic [3:0] sat_credit(input logic [4:0] sum);
    if (sum > 5'(IQ_DEPTH)) return IQ_MAX;
    else return sum[3:0];
  endfunction

  // Number of issue-queue entries released this cycle.
  function automatic logic [3:0] popcnt7(input logic [6:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 7; i++) c = c + 4'(v[i]);
    return c;
  endfunction

  // Entry 7 of the release vector does not exist in a 7-entry queue.
  assign unused_out_en7 = iq_out_en[7];

  assign space       = DEPTH_C - count_p0;
  assign fetch_ready = (space >= CNT_W'(2));
  assign fifo_count  = count_p0;
  assign iq_free     = free_p0;

  // Push and dispatch counts from registered state; flush suppresses both.
  always_comb begin
    push_n = 2'd0;
    if (fetch_ready && !flush) begin
      case (fetch_valid)
        2'b01:   push_n = 2'd1;
        2'b11:   push_n = 2'd2;
        default: push_n = 2'd0;
      endcase
    end
    pop_n = 2'd2;
    if (32'(count_p0) < 32'(pop_n)) pop_n = count_p0[1:0];
    if (32'(free_p0) < 32'(pop_n))  pop_n = free_p0[1:0];
    if (flush) pop_n = 2'd0;
    ret_n      = popcnt7(iq_out_en[6:0]);
    credit_sum = 5'(free_p0) + 5'(ret_n) - 5'(pop_n);
  end

  // Issue-queue write port: n=1 -> 01, n=2 -> 11, unused lanes forced to zero.
  always_comb begin
    iq_wen   = {pop_n[1], |pop_n};
    iq_inst0 = iq_wen[0] ? mem_p0[rd_ptr_p0] : '0;
    iq_inst1 = iq_wen[1] ? mem_p0[rd_ptr_p0 + PTR_W'(1)] : '0;
  end

  // Control state: pointers, occupancy and credits; flush wins over everything.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_p0 <= '0;
      wr_ptr_p0 <= '0;
      count_p0  <= '0;
      free_p0   <= IQ_MAX;
    end else if (flush) begin
      rd_ptr_p0 <= '0;
      wr_ptr_p0 <= '0;
      count_p0  <= '0;
      free_p0   <= IQ_MAX;
    end else begin
      rd_ptr_p0 <= rd_ptr_p0 + PTR_W'(pop_n);
      wr_ptr_p0 <= wr_ptr_p0 + PTR_W'(push_n);
      count_p0  <= count_p0 + CNT_W'(push_n) - CNT_W'(pop_n);
      free_p0   <= sat_credit(credit_sum);
    end
  end

  // FIFO storage: written in fetch order, never reset.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) mem_p0[wr_ptr_p0] <= fetch_inst0;
    if (push_n == 2'd2) mem_p0[wr_ptr_p0 + PTR_W'(1)] <= fetch_inst1;
  end

`ifndef SYNTHESIS
  // Releasing more entries than were ever dispatched is an issue-queue protocol error.
  always @(posedge clk) begin
    if (resetn && !flush)
      assert (credit_sum <= 5'(IQ_DEPTH))
        else $error("dispatch_unit: credit overflow %0d", credit_sum);
  end
`endif

endmodule

// File: tb/tb_dispatch_unit.sv
// Directed bench for dispatch_unit with hand-computed expected values.
module tb_dispatch_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic [1:0]  fetch_valid;
  logic [31:0] fetch_inst0;
  logic [31:0] fetch_inst1;
  logic        fetch_ready;
  logic [31:0] iq_inst0;
  logic [31:0] iq_inst1;
  logic [1:0]  iq_wen;
  logic [7:0]  iq_out_en;
  logic [3:0]  iq_free;
  logic [3:0]  fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0]  wen_e  [5];
  logic [31:0] i0_e   [5];
  logic [31:0] i1_e   [5];
  logic [3:0]  cnt_e  [5];
  logic [3:0]  free_e [5];

  always #5 clk = ~clk;

  dispatch_unit #(.DATA_W(32), .FIFO_DEPTH(8), .IQ_DEPTH(7)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .fetch_valid(fetch_valid),
    .fetch_inst0(fetch_inst0),
    .fetch_inst1(fetch_inst1),
    .fetch_ready(fetch_ready),
    .iq_inst0   (iq_inst0),
    .iq_inst1   (iq_inst1),
    .iq_wen     (iq_wen),
    .iq_out_en  (iq_out_en),
    .iq_free    (iq_free),
    .fifo_count (fifo_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] wen, input logic [31:0] i0,
                         input logic [31:0] i1, input logic [3:0] cnt, input logic [3:0] free,
                         input logic rdy);
    chk({tag, ".wen"},   64'(iq_wen),      64'(wen));
    chk({tag, ".inst0"}, 64'(iq_inst0),    64'(i0));
    chk({tag, ".inst1"}, 64'(iq_inst1),    64'(i1));
    chk({tag, ".count"}, 64'(fifo_count),  64'(cnt));
    chk({tag, ".free"},  64'(iq_free),     64'(free));
    chk({tag, ".ready"}, 64'(fetch_ready), 64'(rdy));
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b,
                       input logic [7:0] oe);
    fetch_valid = v;
    fetch_inst0 = a;
    fetch_inst1 = b;
    iq_out_en   = oe;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] A(input int k); return 32'hA000_0000 + 32'(k); endfunction
  function automatic logic [31:0] B(input int k); return 32'hB000_0000 + 32'(k); endfunction
  function automatic logic [31:0] C(input int k); return 32'hC000_0000 + 32'(k); endfunction
  function automatic logic [31:0] D(input int k); return 32'hD000_0000 + 32'(k); endfunction

  initial begin
    resetn = 1'b1;
    flush  = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 8'h00);
    #2 resetn = 1'b0;
    #1 chk_out("reset", 2'b00, 0, 0, 0, 7, 1'b1);
    repeat (2) tick;
    resetn = 1'b1;

    // Illegal valid pattern accepts nothing
    drive(2'b10, 32'h1111, 32'h2222, 8'h00);
    tick;
    drive(2'b00, 0, 0, 8'h00);
    chk_out("illegal", 2'b00, 0, 0, 0, 7, 1'b1);

    // Single instruction
    drive(2'b01, 32'h0000_0013, 32'hDEAD_BEEF, 8'h00);
    tick;
    drive(2'b00, 0, 0, 8'h00);
    chk_out("single", 2'b01, 32'h13, 0, 1, 7, 1'b1);
    tick;
    chk_out("single_pop", 2'b00, 0, 0, 0, 6, 1'b1);
    drive(2'b00, 0, 0, 8'h01);
    tick;
    drive(2'b00, 0, 0, 8'h00);
    chk_out("single_ret", 2'b00, 0, 0, 0, 7, 1'b1);

    // Credit exhaustion: five pairs, no releases
    wen_e  = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b00};
    i0_e   = '{A(0), A(2), A(4), A(6), 32'h0};
    i1_e   = '{A(1), A(3), A(5), 32'h0, 32'h0};
    cnt_e  = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd3};
    free_e = '{4'd7, 4'd5, 4'd3, 4'd1, 4'd0};
    for (int k = 0; k < 5; k++) begin
      drive(2'b11, A(2*k), A(2*k+1), 8'h00);
      tick;
      chk_out($sformatf("exhaust%0d", k), wen_e[k], i0_e[k], i1_e[k], cnt_e[k], free_e[k], 1'b1);
    end
    drive(2'b00, 0, 0, 8'h03);
    tick;
    drive(2'b00, 0, 0, 8'h00);
    chk_out("credit2", 2'b11, A(7), A(8), 3, 2, 1'b1);
    tick;
    chk_out("credit0", 2'b00, 0, 0, 1, 0, 1'b1);

    // Backpressure: fill to 7 entries with no credits
    drive(2'b11, B(0), B(1), 8'h00);
    tick;
    chk_out("fill3", 2'b00, 0, 0, 3, 0, 1'b1);
    drive(2'b11, B(2), B(3), 8'h00);
    tick;
    chk_out("fill5", 2'b00, 0, 0, 5, 0, 1'b1);
    drive(2'b11, B(4), B(5), 8'h00);
    tick;
    chk_out("full", 2'b00, 0, 0, 7, 0, 1'b0);
    // Not ready: this pair must be ignored; all seven queue entries leave
    drive(2'b11, 32'hBAD0_0000, 32'hBAD0_0001, 8'h7F);
    tick;
    drive(2'b00, 0, 0, 8'h00);
    chk_out("drain0", 2'b11, A(9), B(0), 7, 7, 1'b0);
    tick;
    chk_out("drain1", 2'b11, B(1), B(2), 5, 5, 1'b1);
    tick;
    chk_out("drain2", 2'b11, B(3), B(4), 3, 3, 1'b1);
    tick;
    chk_out("drain3", 2'b01, B(5), 0, 1, 1, 1'b1);
    tick;
    chk_out("drain4", 2'b00, 0, 0, 0, 0, 1'b1);

    // Simultaneous push and pop in steady state
    drive(2'b11, C(0), C(1), 8'h7F);
    tick;
    chk_out("pp_fill", 2'b11, C(0), C(1), 2, 7, 1'b1);
    drive(2'b11, C(2), C(3), 8'h00);
    tick;
    chk_out("pp_start", 2'b11, C(2), C(3), 2, 5, 1'b1);
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, C(2*k+4), C(2*k+5), 8'h03);
      tick;
      chk_out($sformatf("pp%0d", k), 2'b11, C(2*k+4), C(2*k+5), 2, 5, 1'b1);
    end

    // Build count=5, free=1, then flush
    drive(2'b11, D(0), D(1), 8'h00);
    tick;
    chk_out("pre_f0", 2'b11, D(0), D(1), 2, 3, 1'b1);
    drive(2'b11, D(2), D(3), 8'h00);
    tick;
    chk_out("pre_f1", 2'b01, D(2), 0, 2, 1, 1'b1);
    drive(2'b11, D(4), D(5), 8'h00);
    tick;
    chk_out("pre_f2", 2'b00, 0, 0, 3, 0, 1'b1);
    drive(2'b11, D(6), D(7), 8'h01);
    tick;
    chk_out("pre_f3", 2'b01, D(3), 0, 5, 1, 1'b1);
    flush = 1'b1;
    drive(2'b11, 32'hE000_0000, 32'hE000_0001, 8'h03);
    #1 chk_out("flush_cyc", 2'b00, 0, 0, 5, 1, 1'b1);
    tick;
    flush = 1'b0;
    drive(2'b01, 32'hF000_0000, 32'h0, 8'h00);
    chk_out("post_flush", 2'b00, 0, 0, 0, 7, 1'b1);
    tick;
    chk_out("post_flush_data", 2'b01, 32'hF000_0000, 0, 1, 7, 1'b1);

    // Asynchronous reset with the FIFO non-empty
    drive(2'b11, 32'h6000_0000, 32'h6000_0001, 8'h00);
    tick;
    drive(2'b00, 0, 0, 8'h00);
    chk_out("pre_rst", 2'b11, 32'h6000_0000, 32'h6000_0001, 2, 6, 1'b1);
    #1 resetn = 1'b0;
    #1 chk_out("async_rst", 2'b00, 0, 0, 0, 7, 1'b1);
    #1 resetn = 1'b1;
    tick;
    chk_out("after_rst", 2'b00, 0, 0, 0, 7, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
